xif_mac_coproc: RTL and testbench

Multiply-accumulate coprocessor on the CORE-V-XIF (v0.2 signalling) and the consumer of the core-side issue, commit and result channels exported by the CV32E20 X-IF bridge. Accepts custom-0 instructions, waits for commit, updates a 32-bit accumulator and writes a result back to the core's register file. It is instantiated beside the core in the MCU whenever the X interface is enabled.

---
 rtl/xif_mac_coproc.sv | 174 +++++++++++++++++
 tb/tb_xif_mac_coproc.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_mac_coproc.sv
// xif_mac_coproc: multiply-accumulate coprocessor on the CORE-V-XIF issue/commit/result channels.
// Accepts custom-0 MAC/CLR/RD, waits for commit, updates a 32-bit accumulator, writes rd back.
// Build option: define XIF_MAC_FAST_EN for a single-cycle 32x32 multiplier; otherwise an
// iterative shift-add multiplier handles MAC over 32 EXEC cycles with identical results.
module xif_mac_coproc #(
  parameter int X_ID_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [1:0][31:0]      issue_rs_i,
  input  logic [1:0]            issue_rs_valid_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [31:0]           result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o
);

  typedef enum logic [1:0] {IDLE, WAIT_COMMIT, EXEC, RESULT} state_t;

  localparam logic [1:0] OP_MAC = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;

  state_t                state;
  state_t                state_next;
  logic [X_ID_WIDTH-1:0] id_q;
  logic [4:0]            rd_q;
  logic [1:0]            op_q;
  logic [31:0]           rs1_q;
  logic [31:0]           rs2_q;
  logic [31:0]           acc;
  logic [31:0]           res;
  logic [31:0]           mac_sum;
  logic                  match;
  logic                  handshake;
  logic                  exec_last;
  logic                  unused_instr;

  // Register-address fields of the instruction are irrelevant: operands arrive as values.
  assign unused_instr = ^issue_instr_i[24:15];

  assign match = (issue_instr_i[6:0] == 7'b0001011) && (issue_instr_i[31:25] == 7'd0) &&
                 ((issue_instr_i[14:12] == 3'b000) || (issue_instr_i[14:12] == 3'b001) ||
                  (issue_instr_i[14:12] == 3'b010));

  // Accept/writeback depend only on the instruction word, forced low while reset is held.
  assign issue_accept_o    = rst_ni && match;
  assign issue_writeback_o = rst_ni && match;
  assign handshake         = issue_valid_i && issue_ready_o && match;

  assign result_id_o   = id_q;
  assign result_rd_o   = rd_q;
  assign result_data_o = res;

`ifdef XIF_MAC_FAST_EN
  assign mac_sum   = acc + rs1_q * rs2_q;
  assign exec_last = 1'b1;
`else
  logic [4:0]  cnt;
  logic [31:0] prod;
  logic [31:0] prod_next;

  assign prod_next = prod + (rs2_q[0] ? rs1_q : 32'd0);
  assign mac_sum   = acc + prod_next;
  assign exec_last = (op_q != OP_MAC) || (cnt == 5'd31);

  // Shift-add multiplier: one multiplier bit per EXEC cycle, partial product restarts per issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt  <= 5'd0;
      prod <= 32'd0;
    end else if (handshake) begin
      cnt  <= 5'd0;
      prod <= 32'd0;
    end else if (state == EXEC && op_q == OP_MAC) begin
      cnt  <= cnt + 5'd1;
      prod <= prod_next;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; a commit in the issue cycle is matched against the incoming id.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          if (commit_valid_i && commit_id_i == issue_id_i)
            state_next = commit_kill_i ? IDLE : EXEC;
          else
            state_next = WAIT_COMMIT;
        end
      end
      WAIT_COMMIT: begin
        if (commit_valid_i && commit_id_i == id_q)
          state_next = commit_kill_i ? IDLE : EXEC;
      end
      EXEC:    if (exec_last) state_next = RESULT;
      RESULT:  if (result_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs; a matching instruction waits in IDLE until both operands are valid.
  always_comb begin
    issue_ready_o  = 1'b0;
    result_valid_o = 1'b0;
    result_we_o    = 1'b0;
    if (rst_ni) begin
      case (state)
        IDLE:    issue_ready_o = !match || (issue_rs_valid_i == 2'b11);
        RESULT: begin
          result_valid_o = 1'b1;
          result_we_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand capture at issue and accumulator/result update in the final EXEC cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q  <= '0;
      rd_q  <= 5'd0;
      op_q  <= 2'b00;
      rs1_q <= 32'd0;
      rs2_q <= 32'd0;
      acc   <= 32'd0;
      res   <= 32'd0;
    end else if (handshake) begin
      id_q  <= issue_id_i;
      rd_q  <= issue_instr_i[11:7];
      op_q  <= issue_instr_i[13:12];
      rs1_q <= issue_rs_i[0];
      rs2_q <= issue_rs_i[1];
    end else if (state == EXEC) begin
`ifndef XIF_MAC_FAST_EN
      if (op_q == OP_MAC) begin
        rs1_q <= rs1_q << 1;
        rs2_q <= rs2_q >> 1;
      end
`endif
      if (exec_last) begin
        if (op_q == OP_MAC) begin
          acc <= mac_sum;
          res <= mac_sum;
        end else if (op_q == OP_CLR) begin
          res <= acc;
          acc <= 32'd0;
        end else begin
          res <= acc;
        end
      end
    end
  end

endmodule

// File: tb/tb_xif_mac_coproc.sv
// tb_xif_mac_coproc: randomized self-checking bench for xif_mac_coproc with a behavioural
// accumulator model and an expected-result queue checked every cycle the result is valid.
module tb_xif_mac_coproc;

`ifdef XIF_MAC_FAST_EN
  localparam int MAC_LEN = 1;
`else
  localparam int MAC_LEN = 32;
`endif

  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
    logic [4:0]  rd;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            issue_valid;
  logic            issue_ready_o;
  logic [31:0]     issue_instr;
  logic [3:0]      issue_id;
  logic [1:0][31:0] issue_rs;
  logic [1:0]      issue_rs_valid;
  logic            issue_accept_o;
  logic            issue_writeback_o;
  logic            commit_valid;
  logic [3:0]      commit_id;
  logic            commit_kill;
  logic            result_valid_o;
  logic            result_ready;
  logic [3:0]      result_id_o;
  logic [31:0]     result_data_o;
  logic [4:0]      result_rd_o;
  logic            result_we_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] acc_m = 32'd0;
  exp_t        exp_q[$];
  logic [31:0] last_data = 32'd0;
  logic [4:0]  last_rd = 5'd0;
  logic [3:0]  last_id = 4'd0;

  xif_mac_coproc #(.X_ID_WIDTH(4)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .issue_valid_i     (issue_valid),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr),
    .issue_id_i        (issue_id),
    .issue_rs_i        (issue_rs),
    .issue_rs_valid_i  (issue_rs_valid),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .commit_valid_i    (commit_valid),
    .commit_id_i       (commit_id),
    .commit_kill_i     (commit_kill),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready),
    .result_id_o       (result_id_o),
    .result_data_o     (result_data_o),
    .result_rd_o       (result_rd_o),
    .result_we_o       (result_we_o)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mkInstr(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd9, 5'd7, f3, rd, opc};
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_issue_ready"}, 32'(issue_ready_o), 32'd0);
    checkOutput({tag, "_accept"}, 32'(issue_accept_o), 32'd0);
    checkOutput({tag, "_writeback"}, 32'(issue_writeback_o), 32'd0);
    checkOutput({tag, "_result_valid"}, 32'(result_valid_o), 32'd0);
    checkOutput({tag, "_result_data"}, result_data_o, 32'd0);
    checkOutput({tag, "_result_id"}, 32'(result_id_o), 32'd0);
    checkOutput({tag, "_result_rd"}, 32'(result_rd_o), 32'd0);
    checkOutput({tag, "_result_we"}, 32'(result_we_o), 32'd0);
  endtask

  // One full transaction: issue (optionally with operands arriving late), commit after cdel
  // cycles (optionally preceded by a mismatched-id kill), then the result held for hold cycles.
  task automatic applyStimulus(input logic [31:0] instr, input logic [3:0] id,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input int cdel, input bit kill, input bit bad_commit,
                               input int hold, input bit rs_late);
    bit          is_match;
    logic [31:0] exp_data;
    int          exp_lat;
    int          cyc;
    exp_t        e;
    is_match = (instr[6:0] == 7'b0001011) && (instr[31:25] == 7'd0) && (instr[14:12] <= 3'd2);
    issue_instr = instr;
    issue_id    = id;
    issue_rs[0] = rs1;
    issue_rs[1] = rs2;
    if (rs_late && is_match) begin
      issue_valid    = 1'b1;
      issue_rs_valid = 2'b01;
      @(negedge clk);
      checkOutput("ready_rs_pending", 32'(issue_ready_o), 32'd0);
      tick();
    end
    issue_valid    = 1'b1;
    issue_rs_valid = 2'b11;
    if (cdel == 0) begin
      commit_valid = 1'b1;
      commit_id    = id;
      commit_kill  = kill;
    end
    @(negedge clk);
    checkOutput("issue_ready", 32'(issue_ready_o), 32'd1);
    checkOutput("issue_accept", 32'(issue_accept_o), 32'(is_match));
    checkOutput("issue_writeback", 32'(issue_writeback_o), 32'(is_match));
    tick();
    issue_valid  = 1'b0;
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
    if (!is_match) begin
      @(negedge clk);
      checkOutput("reject_stays_idle", 32'(issue_ready_o), 32'd1);
      tick();
      return;
    end
    for (int k = 1; k <= cdel; k++) begin
      if (k == cdel) begin
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
      end else if (bad_commit && k == 1) begin
        commit_valid = 1'b1;
        commit_id    = id ^ 4'h1;
        commit_kill  = 1'b1;
      end
      @(negedge clk);
      checkOutput("ready_busy", 32'(issue_ready_o), 32'd0);
      tick();
      commit_valid = 1'b0;
      commit_kill  = 1'b0;
    end
    if (kill) begin
      @(negedge clk);
      checkOutput("kill_idle", 32'(issue_ready_o), 32'd1);
      checkOutput("kill_no_result", 32'(result_valid_o), 32'd0);
      tick();
      return;
    end
    case (instr[14:12])
      3'b000: begin
        acc_m    = acc_m + rs1 * rs2;
        exp_data = acc_m;
      end
      3'b001: begin
        exp_data = acc_m;
        acc_m    = 32'd0;
      end
      default: exp_data = acc_m;
    endcase
    e.data = exp_data;
    e.id   = id;
    e.rd   = instr[11:7];
    exp_q.push_back(e);
    exp_lat = cdel + 1 + ((instr[14:12] == 3'b000) ? MAC_LEN : 1);
    result_ready = (hold == 0);
    cyc = cdel + 1;
    while (1) begin
      @(negedge clk);
      if (result_valid_o || cyc > 200) break;
      cyc++;
      tick();
    end
    checkOutput("result_timeout", 32'(result_valid_o), 32'd1);
    checkOutput("latency", cyc, exp_lat);
    if (hold > 0) begin
      repeat (hold) tick();
      result_ready = 1'b1;
      @(negedge clk);
    end
    tick();
    result_ready = 1'b0;
    @(negedge clk);
    checkOutput("after_result_valid", 32'(result_valid_o), 32'd0);
    checkOutput("after_result_idle", 32'(issue_ready_o), 32'd1);
    tick();
  endtask

  // Every cycle a result is presented it must match the oldest expected entry exactly.
  always @(negedge clk) begin
    if (rst_ni && result_valid_o) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_result", 32'(result_valid_o), 32'd0);
      end else begin
        checkOutput("result_data", result_data_o, exp_q[0].data);
        checkOutput("result_id", 32'(result_id_o), 32'(exp_q[0].id));
        checkOutput("result_rd", 32'(result_rd_o), 32'(exp_q[0].rd));
        checkOutput("result_we", 32'(result_we_o), 32'd1);
        checkOutput("ready_during_result", 32'(issue_ready_o), 32'd0);
        last_data = result_data_o;
        last_rd   = result_rd_o;
        last_id   = result_id_o;
        if (result_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Hard stop in case a wait is ever left unbounded.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [2:0]  f3;
    int          sel;
    int          cdel;
    rst_ni         = 1'b0;
    issue_valid    = 1'b1;
    issue_instr    = mkInstr(7'd0, 3'b000, 5'd1, 7'b0001011);
    issue_id       = 4'd0;
    issue_rs[0]    = 32'd0;
    issue_rs[1]    = 32'd0;
    issue_rs_valid = 2'b11;
    commit_valid   = 1'b0;
    commit_id      = 4'd0;
    commit_kill    = 1'b0;
    result_ready   = 1'b0;
    @(negedge clk);
    checkAllZero("reset");
    tick();
    issue_valid = 1'b0;
    rst_ni      = 1'b1;
    tick();

    $display("[TB] directed sequence");
    applyStimulus(mkInstr(7'd0, 3'b000, 5'd5, 7'b0001011), 4'd2, 32'd3, 32'd5, 1, 0, 0, 0, 0);
    checkOutput("lit_mac_data", last_data, 32'd15);
    checkOutput("lit_mac_rd", 32'(last_rd), 32'd5);
    checkOutput("lit_mac_id", 32'(last_id), 32'd2);
    applyStimulus(mkInstr(7'd0, 3'b000, 5'd6, 7'b0001011), 4'd3, 32'hFFFF_FFFF, 32'd2, 1, 0, 0, 0, 0);
    checkOutput("lit_mac_wrap", last_data, 32'h0000_000D);
    applyStimulus(mkInstr(7'd0, 3'b001, 5'd7, 7'b0001011), 4'd4, 32'd0, 32'd0, 0, 0, 0, 1, 0);
    checkOutput("lit_clr", last_data, 32'h0000_000D);
    applyStimulus(mkInstr(7'd0, 3'b010, 5'd8, 7'b0001011), 4'd5, 32'd0, 32'd0, 2, 0, 0, 0, 0);
    checkOutput("lit_rd_after_clr", last_data, 32'd0);
    applyStimulus(mkInstr(7'd0, 3'b000, 5'd9, 7'b0001011), 4'd6, 32'd4, 32'd4, 0, 0, 0, 0, 0);
    checkOutput("lit_mac16", last_data, 32'd16);
    applyStimulus(mkInstr(7'd0, 3'b000, 5'd9, 7'b0001011), 4'd2, 32'd7, 32'd9, 1, 1, 0, 0, 0);
    applyStimulus(mkInstr(7'd0, 3'b010, 5'd10, 7'b0001011), 4'd1, 32'd0, 32'd0, 1, 0, 0, 0, 0);
    checkOutput("lit_rd_after_kill", last_data, 32'd16);
    applyStimulus(mkInstr(7'd0, 3'b000, 5'd3, 7'b0110011), 4'd1, 32'd1, 32'd1, 1, 0, 0, 0, 0);
    applyStimulus(mkInstr(7'd0, 3'b000, 5'd11, 7'b0001011), 4'd7, 32'd2, 32'd3, 3, 0, 1, 5, 1);
    checkOutput("lit_mac_held", last_data, 32'd22);

    $display("[TB] reset during EXEC");
    issue_instr    = mkInstr(7'd0, 3'b000, 5'd12, 7'b0001011);
    issue_id       = 4'd9;
    issue_rs[0]    = 32'd11;
    issue_rs[1]    = 32'd13;
    issue_rs_valid = 2'b11;
    issue_valid    = 1'b1;
    commit_valid   = 1'b1;
    commit_id      = 4'd9;
    commit_kill    = 1'b0;
    tick();
    commit_valid = 1'b0;
    rst_ni       = 1'b0;
    #1;
    checkAllZero("rst_exec");
    @(negedge clk);
    checkAllZero("rst_hold");
    tick();
    issue_valid = 1'b0;
    rst_ni      = 1'b1;
    acc_m       = 32'd0;
    exp_q.delete();
    tick();
    applyStimulus(mkInstr(7'd0, 3'b010, 5'd13, 7'b0001011), 4'd3, 32'd0, 32'd0, 1, 0, 0, 0, 0);
    checkOutput("lit_rd_after_reset", last_data, 32'd0);

    $display("[TB] random sequence");
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      opc = 7'b0001011;
      f3  = (sel < 4) ? 3'b000 : (sel == 4) ? 3'b001 : (sel < 7) ? 3'b010 : 3'b000;
      if (sel == 7) f3 = 3'($urandom_range(3, 7));
      instr = mkInstr((sel == 8) ? 7'($urandom_range(1, 127)) : 7'd0, f3, 5'($urandom), opc);
      if (sel == 9) begin
        opc = 7'($urandom);
        if (opc == 7'b0001011) opc = 7'b0110011;
        instr[6:0] = opc;
      end
      cdel = $urandom_range(0, 3);
      applyStimulus(instr, 4'($urandom), ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)),
                    $urandom, cdel, $urandom_range(0, 4) == 0,
                    (cdel >= 2) && ($urandom_range(0, 1) == 1), $urandom_range(0, 3),
                    $urandom_range(0, 1) == 1);
    end
    applyStimulus(mkInstr(7'd0, 3'b010, 5'd14, 7'b0001011), 4'd0, 32'd0, 32'd0, 1, 0, 0, 0, 0);
    checkOutput("final_acc", last_data, acc_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
